// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// arbiter state encoding and the default register-file geometry.
package rf_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [0:0] arbState_t;

  localparam arbState_t ARB   = 1'b0;
  localparam arbState_t FORCE = 1'b1;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of CPU writeback, debug loader and regfile write-port signals.
// The arbiter is the slave; the surrounding datapath or a bench is the master.
interface regfile_wport_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) ();

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              cpu_stall;

  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  modport master (
    output wb_we, wb_addr, wb_data,
    output dbg_valid, dbg_addr, dbg_data,
    input  cpu_stall, dbg_ready,
    input  rf_we, rf_addr, rf_data
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  dbg_valid, dbg_addr, dbg_data,
    output cpu_stall, dbg_ready,
    output rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between CPU writeback (priority) and a one-entry
// debug buffer; a starved debug write forces a single-cycle CPU stall.
module regfile_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = REG_DATA_W,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int STARVE_LIMIT = 4,
  parameter bit ZERO_GUARD   = 1'b1
) (
  input logic                    clock,
  input logic                    reset,
  regfile_wport_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(STARVE_LIMIT - 1);

  arbState_t         r_state;
  logic              r_holdV;
  logic [ADDR_W-1:0] r_holdAddr;
  logic [DATA_W-1:0] r_holdData;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              r_rfWe;
  logic [ADDR_W-1:0] r_rfAddr;
  logic [DATA_W-1:0] r_rfData;

  logic              w_dbgReady;
  logic              w_accept;
  logic              w_issueCpu;
  logic              w_issueDbg;
  logic              w_issue;
  logic              w_trip;
  logic              w_zeroHit;
  logic [ADDR_W-1:0] w_issueAddr;
  logic [DATA_W-1:0] w_issueData;

  // In FORCE the held entry is always valid, so the debug path wins unconditionally.
  always_comb begin
    w_dbgReady  = reset & ~r_holdV;
    w_accept    = bus.dbg_valid & w_dbgReady;
    w_issueCpu  = (r_state == ARB) & bus.wb_we;
    w_issueDbg  = r_holdV & ((r_state == FORCE) | ~bus.wb_we);
    w_issue     = w_issueCpu | w_issueDbg;
    w_issueAddr = w_issueCpu ? bus.wb_addr : r_holdAddr;
    w_issueData = w_issueCpu ? bus.wb_data : r_holdData;
    w_trip      = (r_state == ARB) & r_holdV & bus.wb_we & (r_waitCnt == CNT_TRIP);
    w_zeroHit   = ZERO_GUARD & (w_issueAddr == ADDR_W'(REG_ZERO));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ARB;
      r_holdV    <= 1'b0;
      r_holdAddr <= '0;
      r_holdData <= '0;
      r_waitCnt  <= '0;
      r_rfWe     <= 1'b0;
      r_rfAddr   <= '0;
      r_rfData   <= '0;
    end else begin
      r_state <= w_trip ? FORCE : ARB;

      if (w_issue) begin
        r_rfWe   <= ~w_zeroHit;
        r_rfAddr <= w_issueAddr;
        r_rfData <= w_issueData;
      end else begin
        r_rfWe <= 1'b0;
      end

      // Accept and debug issue are exclusive: accept needs an empty buffer.
      if (w_issueDbg) begin
        r_holdV   <= 1'b0;
        r_waitCnt <= '0;
      end else if (w_accept) begin
        r_holdV    <= 1'b1;
        r_holdAddr <= bus.dbg_addr;
        r_holdData <= bus.dbg_data;
      end else if (r_holdV && (r_waitCnt != CNT_MAX)) begin
        r_waitCnt <= r_waitCnt + CNT_W'(1);
      end
    end
  end

  assign bus.cpu_stall = (r_state == FORCE);
  assign bus.dbg_ready = w_dbgReady;
  assign bus.rf_we     = r_rfWe;
  assign bus.rf_addr   = r_rfAddr;
  assign bus.rf_data   = r_rfData;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: reset, vector table, and
// hand-written reset-during-FORCE sequence.
module tb_regfile_wport_arbiter;

  typedef struct {
    logic        wbWe;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        dbgValid;
    logic [4:0]  dbgAddr;
    logic [31:0] dbgData;
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    logic        expStall;
    logic        expReady;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wport_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .ZERO_GUARD(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  function automatic vec_t mkVec(
    input logic wbWe, input logic [4:0] wbAddr, input logic [31:0] wbData,
    input logic dbgValid, input logic [4:0] dbgAddr, input logic [31:0] dbgData,
    input logic expWe, input logic [4:0] expAddr, input logic [31:0] expData,
    input logic expStall, input logic expReady);
    vec_t v;
    v.wbWe = wbWe; v.wbAddr = wbAddr; v.wbData = wbData;
    v.dbgValid = dbgValid; v.dbgAddr = dbgAddr; v.dbgData = dbgData;
    v.expWe = expWe; v.expAddr = expAddr; v.expData = expData;
    v.expStall = expStall; v.expReady = expReady;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data, input logic stall, input logic ready);
    checkOutput({tag, " rf_we"},     32'(bus.rf_we),     32'(we));
    checkOutput({tag, " rf_addr"},   32'(bus.rf_addr),   32'(addr));
    checkOutput({tag, " rf_data"},   bus.rf_data,        data);
    checkOutput({tag, " cpu_stall"}, 32'(bus.cpu_stall), 32'(stall));
    checkOutput({tag, " dbg_ready"}, 32'(bus.dbg_ready), 32'(ready));
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic applyStimulus(input logic wbWe, input logic [4:0] wbAddr,
                               input logic [31:0] wbData, input logic dbgValid,
                               input logic [4:0] dbgAddr, input logic [31:0] dbgData);
    @(negedge clock);
    bus.wb_we     = wbWe;
    bus.wb_addr   = wbAddr;
    bus.wb_data   = wbData;
    bus.dbg_valid = dbgValid;
    bus.dbg_addr  = dbgAddr;
    bus.dbg_data  = dbgData;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Simple write, debug load, starvation run, zero-register guard, same-register race.
    vecs.push_back(mkVec(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 1));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 0, 5'd5,  32'hDEADBEEF, 0, 0));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd7,  32'h12345678, 0, 1));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd7,  32'h12345678, 0, 1));
    vecs.push_back(mkVec(1, 5'd1,  32'h11,       1, 5'd9,  32'h99,       1, 5'd1,  32'h11,       0, 0));
    vecs.push_back(mkVec(1, 5'd2,  32'h22,       0, 5'd0,  32'h0,        1, 5'd2,  32'h22,       0, 0));
    vecs.push_back(mkVec(1, 5'd3,  32'h33,       0, 5'd0,  32'h0,        1, 5'd3,  32'h33,       0, 0));
    vecs.push_back(mkVec(1, 5'd4,  32'h44,       0, 5'd0,  32'h0,        1, 5'd4,  32'h44,       0, 0));
    vecs.push_back(mkVec(1, 5'd6,  32'h66,       0, 5'd0,  32'h0,        1, 5'd6,  32'h66,       1, 0));
    vecs.push_back(mkVec(1, 5'd8,  32'h88,       0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 1));
    vecs.push_back(mkVec(1, 5'd10, 32'hAA,       0, 5'd0,  32'h0,        1, 5'd10, 32'hAA,       0, 1));
    vecs.push_back(mkVec(1, 5'd0,  32'hBAD,      0, 5'd0,  32'h0,        0, 5'd0,  32'hBAD,      0, 1));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        1, 5'd0,  32'hF00D,     0, 5'd0,  32'hBAD,      0, 0));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'hF00D,     0, 1));
    vecs.push_back(mkVec(1, 5'd12, 32'h1111,     1, 5'd12, 32'h2222,     1, 5'd12, 32'h1111,     0, 0));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd12, 32'h2222,     0, 1));
    vecs.push_back(mkVec(1, 5'd14, 32'h4444,     1, 5'd13, 32'h3333,     1, 5'd14, 32'h4444,     0, 0));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        1, 5'd15, 32'h5555,     1, 5'd13, 32'h3333,     0, 1));
    vecs.push_back(mkVec(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd13, 32'h3333,     0, 1));

    reset         = 1'b0;
    bus.wb_we     = 1'b1;
    bus.wb_addr   = 5'd3;
    bus.wb_data   = 32'hCAFE0001;
    bus.dbg_valid = 1'b1;
    bus.dbg_addr  = 5'd4;
    bus.dbg_data  = 32'hCAFE0002;
    repeat (2) begin
      @(posedge clock);
      #1;
      checkCycle("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end

    @(negedge clock);
    reset         = 1'b1;
    bus.wb_we     = 1'b0;
    bus.dbg_valid = 1'b0;
    #1;
    checkOutput("release dbg_ready", 32'(bus.dbg_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wbWe, vecs[i].wbAddr, vecs[i].wbData,
                    vecs[i].dbgValid, vecs[i].dbgAddr, vecs[i].dbgData);
      checkCycle($sformatf("vec%0d", i), vecs[i].expWe, vecs[i].expAddr,
                 vecs[i].expData, vecs[i].expStall, vecs[i].expReady);
    end

    // Drive into FORCE with a held write, then pull reset during the stall cycle.
    applyStimulus(1, 5'd20, 32'hA0, 1, 5'd21, 32'hB1);
    checkCycle("starve accept", 1'b1, 5'd20, 32'hA0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1, 5'(20 + k), 32'(32'hA0 + k), 0, 5'd0, 32'h0);
      checkCycle($sformatf("starve cpu%0d", k), 1'b1, 5'(20 + k),
                 32'(32'hA0 + k), (k == 4), 1'b0);
    end

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkCycle("reset in force", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);

    @(negedge clock);
    reset         = 1'b1;
    bus.wb_we     = 1'b0;
    bus.dbg_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      checkCycle($sformatf("after force reset%0d", k), 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
